// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared port-index type, FSM states and round-robin selection for sdram_arbiter
package sdram_arb_pkg;
    localparam int MaxPorts = 4;
    typedef logic [1:0] PortIdx;
    typedef enum logic {IDLE, ISSUE} State;
    // First set bit of elig strictly after ptr, wrapping at nports; ptr itself is checked last.
    function automatic PortIdx rr_select(input logic [MaxPorts-1:0] elig, input PortIdx ptr, input int nports);
        PortIdx g;
        PortIdx p;
        g = ptr;
        for (int k = nports; k >= 1; k--) begin
            p = PortIdx'((int'(ptr) + k) % nports);
            if (elig[p]) g = p;
        end
        return g;
    endfunction
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: Depth-entry FIFO of port indices for reads awaiting data
//   clk, rst      clock, synchronous active-high reset
//   push_i/tag_i  enqueue tag (accepted when full if pop_i pops in the same cycle)
//   pop_i         dequeue head (ignored when empty)
//   full_o/empty_o/head_o  status and oldest tag
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  PortIdx tag_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output PortIdx head_o
);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    PortIdx mem_q [Depth];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(Depth);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= tag_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM controller command port among NumPorts requesters
//   clk, rst                      clock, synchronous active-high reset
//   portTrigger/portReady         per-port request / combinational one-hot accept
//   portAddr/portWrite/portWriteData  per-port command fields (port i at slice i)
//   portReadData/portReadDataValid    read data broadcast, one-hot owner pulse
//   cmdReady/cmdTrigger/cmdAddr/cmdWrite/cmdWriteData  registered command to controller
//   cmdReadData/cmdReadDataValid      controller read return
//   tagError                      sticky: read data arrived with no outstanding read
// Build option SDRAM_ARB_PRIO0_EN: port 0 has fixed top priority, ports 1..N-1 round-robin.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 23,
    parameter int DataWidth = 16,
    parameter int TagDepth  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts-1:0]           portTrigger,
    output logic [NumPorts-1:0]           portReady,
    input  logic [NumPorts*AddrWidth-1:0] portAddr,
    input  logic [NumPorts-1:0]           portWrite,
    input  logic [NumPorts*DataWidth-1:0] portWriteData,
    output logic [DataWidth-1:0]          portReadData,
    output logic [NumPorts-1:0]           portReadDataValid,
    input  logic                          cmdReady,
    output logic                          cmdTrigger,
    output logic [AddrWidth-1:0]          cmdAddr,
    output logic                          cmdWrite,
    output logic [DataWidth-1:0]          cmdWriteData,
    input  logic [DataWidth-1:0]          cmdReadData,
    input  logic                          cmdReadDataValid,
    output logic                          tagError
);
    State state_q, state_d;
    PortIdx rr_q, rr_d, gnt_q, gnt_d, g, head;
    logic trig_q, trig_d, wr_q, wr_d, tag_err_q, push, tag_full, tag_empty, sel_wr;
    logic [AddrWidth-1:0] addr_q, addr_d, sel_addr;
    logic [DataWidth-1:0] data_q, data_d, sel_data;
    logic [NumPorts-1:0] elig;
    // A full tag FIFO only holds back reads; writes never need a tag.
    assign elig = portTrigger & (portWrite | {NumPorts{!tag_full}});
`ifdef SDRAM_ARB_PRIO0_EN
    assign g = elig[0] ? '0 : rr_select(MaxPorts'(elig) & ~MaxPorts'(1), rr_q, NumPorts);
`else
    assign g = rr_select(MaxPorts'(elig), rr_q, NumPorts);
`endif
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            if (int'(g) == i) begin
                sel_addr = portAddr[i*AddrWidth +: AddrWidth];
                sel_data = portWriteData[i*DataWidth +: DataWidth];
                sel_wr   = portWrite[i];
            end
        end
    end
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        trig_d    = trig_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        portReady = '0;
        push      = 1'b0;
        if (state_q == IDLE) begin
            if (!rst && |elig) begin
                portReady = NumPorts'(1) << g;
                gnt_d     = g;
                addr_d    = sel_addr;
                data_d    = sel_data;
                wr_d      = sel_wr;
                trig_d    = 1'b1;
                state_d   = ISSUE;
`ifdef SDRAM_ARB_PRIO0_EN
                rr_d = (g == '0) ? rr_q : g;
`else
                rr_d = g;
`endif
            end
        end else if (cmdReady) begin
            trig_d  = 1'b0;
            push    = !wr_q;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= PortIdx'(NumPorts - 1);
            gnt_q     <= '0;
            trig_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            trig_q  <= trig_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            if (cmdReadDataValid && tag_empty) tag_err_q <= 1'b1;
        end
    end
    sdram_arb_tag_fifo #(.Depth(TagDepth)) u_tags (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .tag_i  (gnt_q),
        .pop_i  (cmdReadDataValid),
        .full_o (tag_full),
        .empty_o(tag_empty),
        .head_o (head)
    );
    assign cmdTrigger        = trig_q;
    assign cmdAddr           = addr_q;
    assign cmdWrite          = wr_q;
    assign cmdWriteData      = data_q;
    assign tagError          = tag_err_q;
    assign portReadData      = cmdReadData;
    assign portReadDataValid = (cmdReadDataValid && !tag_empty) ? NumPorts'(1) << head : '0;
endmodule
